// File: rtl/lc_line_responder.sv
// lc_line_responder: in-order line request queue and line store standing in for L2/memory.
// Define LC_WRITE_ACK_EN to add the resp_wack_out port and a response beat per write.
module lc_line_responder #(
   parameter int PADDR_BITS    = 22,
   parameter int B             = 64,
   parameter int LINE_IDX_BITS = 6,
   parameter int QUEUE_DEPTH   = 4,
   parameter int LATENCY       = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_N_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [PADDR_BITS-1:0] req_addr_in,
   input  logic [8*B-1:0]        req_value_in,
   input  logic                  req_we_in,
   output logic                  resp_valid_out,
   input  logic                  resp_ready_in,
   output logic [PADDR_BITS-1:0] resp_addr_out,
   output logic [8*B-1:0]        resp_value_out
`ifdef LC_WRITE_ACK_EN
   ,
   output logic                  resp_wack_out
`endif
);

   localparam int OFF_BITS    = $clog2(B);
   localparam int LINE_W      = 8 * B;
   localparam int TAG_W       = PADDR_BITS - OFF_BITS;
   localparam int QA_W        = $clog2(QUEUE_DEPTH);
   localparam int PTR_W       = QA_W + 1;
   localparam int STORE_LINES = 1 << LINE_IDX_BITS;
   localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   // Offset bits never matter: entries keep only the line address.
   logic [TAG_W-1:0]         q_line  [QUEUE_DEPTH];
   logic [LINE_W-1:0]        q_value [QUEUE_DEPTH];
   logic                     q_we    [QUEUE_DEPTH];
   logic [LINE_W-1:0]        store   [STORE_LINES];

   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         occ;
   logic [PTR_W-1:0]         occ_next;
   logic [QA_W-1:0]          wr_slot;
   logic [QA_W-1:0]          rd_slot;
   logic                     fifo_empty;
   logic                     push;
   logic                     pop;

   logic [TAG_W-1:0]         head_line;
   logic [LINE_W-1:0]        head_value;
   logic                     head_we;
   logic [LINE_IDX_BITS-1:0] head_idx;
   logic [PADDR_BITS-1:0]    head_aligned;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic [LINE_IDX_BITS-1:0] rd_idx;
   logic                     offset_unused;

   assign offset_unused = ^req_addr_in[OFF_BITS-1:0];

   assign wr_slot    = wr_ptr[QA_W-1:0];
   assign rd_slot    = rd_ptr[QA_W-1:0];
   assign occ        = wr_ptr - rd_ptr;
   assign fifo_empty = (occ == '0);
   assign push       = req_valid_in & req_ready_out;
   assign pop        = (state == S_IDLE) & ~fifo_empty;
   assign occ_next   = occ + PTR_W'(push) - PTR_W'(pop);

   assign head_line    = q_line[rd_slot];
   assign head_value   = q_value[rd_slot];
   assign head_we      = q_we[rd_slot];
   assign head_idx     = head_line[LINE_IDX_BITS-1:0];
   assign head_aligned = {head_line, {OFF_BITS{1'b0}}};

   always_ff @(posedge clk_in) begin
      if (push) begin
         q_line[wr_slot]  <= req_addr_in[PADDR_BITS-1:OFF_BITS];
         q_value[wr_slot] <= req_value_in;
         q_we[wr_slot]    <= req_we_in;
      end
   end

   // Ready is registered from next occupancy, so a full queue stalls
   // for a cycle even when the head pops on the same edge.
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         req_ready_out <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         req_ready_out <= (occ_next != PTR_W'(QUEUE_DEPTH));
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         for (int i = 0; i < STORE_LINES; i++) store[i] <= '0;
      end else if (pop && head_we) begin
         store[head_idx] <= head_value;
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         state          <= S_IDLE;
         cnt            <= '0;
         rd_idx         <= '0;
         resp_valid_out <= 1'b0;
         resp_addr_out  <= '0;
         resp_value_out <= '0;
`ifdef LC_WRITE_ACK_EN
         resp_wack_out  <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  if (!head_we) begin
                     resp_addr_out <= head_aligned;
                     rd_idx        <= head_idx;
`ifdef LC_WRITE_ACK_EN
                     resp_wack_out <= 1'b0;
`endif
                     if (LATENCY == 1) begin
                        resp_value_out <= store[head_idx];
                        resp_valid_out <= 1'b1;
                        state          <= S_RESP;
                     end else begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= S_WAIT;
                     end
                  end
`ifdef LC_WRITE_ACK_EN
                  else begin
                     resp_addr_out  <= head_aligned;
                     resp_value_out <= '0;
                     resp_wack_out  <= 1'b1;
                     resp_valid_out <= 1'b1;
                     state          <= S_RESP;
                  end
`endif
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  resp_value_out <= store[rd_idx];
                  resp_valid_out <= 1'b1;
                  state          <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready_in) begin
                  resp_valid_out <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lc_line_responder.md
Name: lc_line_responder

Overview:
Lower-level responder for the L1 data cache's LC port. It accepts line-granular read and write requests from the L1D (lc_valid_out/lc_ready_in side), buffers them in order, and services them from an internal line store. Reads return a full 512-bit line after a programmable latency on the fill channel (lc_valid_in/lc_ready_out side). It stands in for L2/memory in cache subsystem simulation and bring-up.

Parameters:
PADDR_BITS, 22, physical address width; must equal the L1D's PADDR_BITS
B, 64, line size in bytes; OFF_BITS = log2(B) = 6
LINE_IDX_BITS, 6, line-store index width; store holds 2^LINE_IDX_BITS lines
QUEUE_DEPTH, 4, request FIFO entries; power of two, >= 2
LATENCY, 4, cycles from read dequeue to resp_valid_out rising; >= 1

Ports:
clk_in  input  1  clock, rising edge
rst_N_in  input  1  asynchronous active-low reset
req_valid_in  input  1  request valid (from L1D lc_valid_out)
req_ready_out  output  1  request accepted (to L1D lc_ready_in)
req_addr_in  input  PADDR_BITS  request byte address
req_value_in  input  8*B  write line data
req_we_in  input  1  1 = write-back line, 0 = line fill read
resp_valid_out  output  1  fill valid (to L1D lc_valid_in)
resp_ready_in  input  1  fill accepted (from L1D lc_ready_out)
resp_addr_out  output  PADDR_BITS  line-aligned address of the fill
resp_value_out  output  8*B  fill data
resp_wack_out  output  1  present only with LC_WRITE_ACK_EN; 1 marks a write-ack beat

Behaviour:
- Reset (rst_N_in low, asynchronous): FIFO empty, FSM in IDLE, counter 0, line store cleared to 0. Outputs: req_ready_out=0 while reset is asserted and 1 on the first cycle after release; resp_valid_out=0; resp_addr_out=0; resp_value_out=0; resp_wack_out=0. Reset mid-operation discards queued and in-flight requests without producing a response.
- Request handshake: transfer occurs when req_valid_in && req_ready_out on a rising edge. req_ready_out = !fifo_full, registered. There is no same-cycle bypass when full: a full FIFO stalls even if a pop occurs in the same cycle. A push and a pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
- FIFO entry holds {addr, value, we}. Pointers are log2(QUEUE_DEPTH)+1 bits wide and wrap naturally.
- Store index = addr[OFF_BITS +: LINE_IDX_BITS]. Higher tag bits are ignored, so aliasing lines share a slot (intended). Offset bits are ignored for storage.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Write: write value into store[index] this edge; stay in IDLE, so the next pop can occur the next cycle.
    - Read: latch the line-aligned address (offset bits forced to 0), set count = LATENCY-1, go to WAIT. If LATENCY==1, go directly to RESP.
  - WAIT: decrement the count; at 0, read store[index] into resp_value_out and go to RESP. The read samples the store at this cycle, so earlier-queued writes are always visible.
  - RESP: resp_valid_out=1, with addr and value held stable until resp_ready_in=1 on an edge. Then return to IDLE and drop resp_valid_out the next cycle.
- Read latency: dequeue at edge t gives resp_valid_out high after edge t+LATENCY. With an empty FIFO and an idle FSM, request acceptance at edge t gives dequeue at t+1.
- Ordering: strictly in order, one outstanding read. Requests keep queueing during WAIT and RESP.
- A write whose index matches a pending read in WAIT cannot occur: writes behind it are not popped until the read completes.

Optional Feature:
LC_WRITE_ACK_EN
- Defined: popping a write also enters RESP. It presents resp_valid_out=1, resp_wack_out=1, resp_addr_out = line-aligned write address, resp_value_out=0, held until resp_ready_in. Read beats drive resp_wack_out=0.
- Undefined: the resp_wack_out port is absent and writes complete silently at pop. Writes consume no response-channel cycles.

Test Plan:
- Reset, then read 0x1040 with LATENCY=4 -> resp_valid_out rises 4 cycles after dequeue; resp_addr_out=0x1040, resp_value_out=0.
- Write 0x2000 with value 512'hDEADBEEF, then read 0x2010 -> one fill, addr=0x2000, value=512'hDEADBEEF.
- Alias check: write 0x1000 with 512'hA, then read 0x1000 + (1<<12) -> value 512'hA.
- Hold resp_ready_in=0 for 10 cycles while pushing 5 reads -> req_ready_out falls after 4 queued; resp_addr_out and resp_value_out stay stable; all 5 fills drain in order once ready returns to 1.
- Assert rst_N_in mid-WAIT with 3 queued -> resp_valid_out=0 immediately; no stale response afterwards; store reads back 0.
- LC_WRITE_ACK_EN defined: write 0x3000 -> ack beat with resp_wack_out=1, resp_addr_out=0x3000; undefined: no beat.
